regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32-bit register bank between NUM_REQ write-back requesters, such as ALU, load unit and vector unit.
- Arbitrates round-robin, one grant per cycle.
- Decodes the granted address into per-register write enables driving each register's WriteEn, and broadcasts the write data to every register's RegIn.
- Sits between the write-back stage and the register bank.

Parameters:
NUM_REQ, 3, number of write requesters (2..8)
NUM_REGS, 16, number of 32-bit registers in the bank (at most 2**ADDR_W)
ADDR_W, 4, register address width
DATA_W, 32, register data width
ZERO_RO, 1, 1 = register 0 is read-only; writes to it are dropped

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-low reset
req  in  NUM_REQ  per-requester write request
req_addr  in  NUM_REQ*ADDR_W  packed target addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  packed write data; requester i uses bits [i*DATA_W +: DATA_W]
gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as req
wr_en  out  NUM_REGS  registered one-hot enables to register WriteEn inputs
wr_data  out  DATA_W  registered write data to all register RegIn inputs
wr_addr  out  ADDR_W  registered address of current write (debug/forwarding)
err_drop  out  1  registered one-cycle pulse: granted write was discarded

Behaviour:
- Reset (reset==0 at a rising edge):
  - ptr<=0, wr_en<=0, wr_data<=0, wr_addr<=0, err_drop<=0.
  - gnt is forced to 0 combinationally while reset==0.
  - Reset has priority over any simultaneous request. A write captured before reset is lost; nothing is replayed.
- Arbitration (combinational):
  - Scan requesters starting at index ptr, wrapping modulo NUM_REQ.
  - Grant the first with req[i]==1: gnt[i]=1, all other gnt bits 0.
  - No req asserted: gnt=0.
- Pointer update:
  - On a grant to index g: ptr <= (g==NUM_REQ-1) ? 0 : g+1.
  - No grant: ptr unchanged.
- Handshake:
  - A requester holds req, addr and data stable until it sees gnt high.
  - The transfer completes in the cycle where req & gnt are both 1.
  - The requester may deassert req or present a new write in the next cycle.
  - Deasserting req before grant withdraws the request; no state is kept.
- Write stage (registered, 1-cycle latency), in the cycle after a grant to g with address A:
  - wr_addr = A, wr_data = req_data of g.
  - wr_en = onehot(A), unless the write is dropped.
  - Dropped when ZERO_RO==1 and A==0, or when A>=NUM_REGS. In that case wr_en=0 and err_drop=1.
  - The grant is still given and consumed, and ptr still advances.
  - The register bank captures on the following edge, so RegOut updates 2 edges after the grant cycle's edge.
- No grant: wr_en=0 and err_drop=0 next cycle. wr_data and wr_addr hold their previous values.
- Invariants:
  - At most one wr_en bit is high in any cycle.
  - gnt is one-hot or zero.
  - Consecutive writes to the same address take effect in grant order; the last one wins.
- Fairness: with all NUM_REQ requesting continuously, each is granted exactly once every NUM_REQ cycles.
- Reset mid-operation: a write in the write stage is cancelled; wr_en is 0 after the reset edge.

Test Plan:
1. Reset low 2 cycles with req=3'b111 -> gnt=0, wr_en=0, err_drop=0. Release reset; the first grant goes to requester 0.
2. req=3'b111 held 6 cycles with distinct addrs 1,2,3 -> gnt sequence 001,010,100,001,010,100. wr_en one cycle later is 0x0002,0x0004,0x0008 repeating.
3. Only req[2] asserted, addr=5, data=0xDEADBEEF -> gnt=100 same cycle. Next cycle wr_en=0x0020, wr_data=0xDEADBEEF, wr_addr=5. Register 5 reads 0xDEADBEEF one edge later.
4. req[1] with addr=0, ZERO_RO=1 -> gnt=010, next cycle wr_en=0 and err_drop=1 for one cycle. ptr advances to 2. Repeat with addr=15 and NUM_REGS=12 -> same drop behaviour.
5. Requesters 0 and 1 both write addr 7: data 0x11111111 then 0x22222222 -> two consecutive wr_en=0x0080 pulses. Register 7 ends at 0x22222222.
6. Grant to req[0] addr=4, then reset=0 on the next edge -> wr_en=0 after that edge and register 4 is unchanged. After release, ptr=0 and arbitration restarts from requester 0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Round-robin arbiter that shares the single write port of the register bank
//   between NUM_REQ write-back requesters. The granted address is decoded into
//   one-hot per-register write enables, and the write data is broadcast to
//   every register input. The write stage is registered (1-cycle latency).
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   reset     : synchronous, active-low reset
//   req       : [NUM_REQ]        per-requester write request
//   req_addr  : [NUM_REQ*ADDR_W] packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data  : [NUM_REQ*DATA_W] packed data, requester i at [i*DATA_W +: DATA_W]
//   gnt       : [NUM_REQ]        one-hot grant, combinational, forced 0 in reset
//   wr_en     : [NUM_REGS]       registered one-hot register write enables
//   wr_data   : [DATA_W]         registered write data to all registers
//   wr_addr   : [ADDR_W]         registered address of the current write
//   err_drop  : registered one-cycle pulse when a granted write was discarded
module regfile_write_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 32,
  parameter int ZERO_RO  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REGS-1:0]         wr_en,
  output logic [DATA_W-1:0]           wr_data,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic                        err_drop
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]    r_ptr;
  logic [NUM_REGS-1:0] r_wr_en;
  logic [DATA_W-1:0]   r_wr_data;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic                r_err_drop;

  logic                w_found;
  logic [PTR_W-1:0]    w_gnt_idx;
  logic [PTR_W-1:0]    w_sel;
  logic [NUM_REQ-1:0]  w_gnt;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_data;
  logic                w_drop;
  logic [NUM_REGS-1:0] w_onehot;

  // Scan from r_ptr upward, wrapping modulo NUM_REQ; first requester wins.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_sel     = '0;
    w_gnt     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_sel = PTR_W'((32'(r_ptr) + k) % NUM_REQ);
      if (!w_found && req[w_sel]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_sel;
      end
    end
    if (!reset) begin
      w_found = 1'b0;
    end
    if (w_found) begin
      w_gnt[w_gnt_idx] = 1'b1;
    end
  end

  // Select the granted requester's address and data.
  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_addr = req_addr[i*ADDR_W +: ADDR_W];
        w_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Writes to a read-only register 0 or past the end of the bank are dropped;
  // the grant is still consumed.
  always_comb begin
    w_drop   = ((ZERO_RO != 0) && (w_addr == '0)) || (32'(w_addr) >= NUM_REGS);
    w_onehot = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      w_onehot[r] = !w_drop && (32'(w_addr) == r);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr      <= '0;
      r_wr_en    <= '0;
      r_wr_data  <= '0;
      r_wr_addr  <= '0;
      r_err_drop <= 1'b0;
    end else if (w_found) begin
      r_ptr      <= (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
      r_wr_en    <= w_onehot;
      r_wr_data  <= w_data;
      r_wr_addr  <= w_addr;
      r_err_drop <= w_drop;
    end else begin
      r_wr_en    <= '0;
      r_err_drop <= 1'b0;
    end
  end

  assign gnt      = w_gnt;
  assign wr_en    = r_wr_en;
  assign wr_data  = r_wr_data;
  assign wr_addr  = r_wr_addr;
  assign err_drop = r_err_drop;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter (3 requesters, 12-register bank so that
// both the read-only register 0 and out-of-range addresses can be exercised).
module tb_regfile_write_arbiter;

  localparam int NR = 3;
  localparam int NG = 12;
  localparam int AW = 4;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    gnt;
  logic [NG-1:0]    wr_en;
  logic [DW-1:0]    wr_data;
  logic [AW-1:0]    wr_addr;
  logic             err_drop;

  regfile_write_arbiter #(
    .NUM_REQ  (NR),
    .NUM_REGS (NG),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .ZERO_RO  (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .gnt      (gnt),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_addr  (wr_addr),
    .err_drop (err_drop)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Register bank driven by the arbiter outputs.
  logic [DW-1:0] bank [NG];
  initial for (int r = 0; r < NG; r++) bank[r] = '0;
  always @(posedge clk) begin
    for (int r = 0; r < NG; r++) begin
      if (wr_en[r]) bank[r] <= wr_data;
    end
  end

  // Scoreboard: each negedge predicts gnt and queues the write-stage result
  // expected after the next rising edge; that result is popped one negedge later.
  typedef struct {
    logic [NG-1:0] en;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          err;
  } wrec_t;

  wrec_t         sb_q[$];
  wrec_t         rec;
  int unsigned   m_ptr = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [NR-1:0] e_gnt;
  int unsigned   g_idx;
  int unsigned   s_idx;
  logic          found;
  logic [AW-1:0] a;
  logic [DW-1:0] d;
  logic          drop;

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      rec = sb_q.pop_front();
      check("wr_en",    64'(wr_en),    64'(rec.en));
      check("wr_data",  64'(wr_data),  64'(rec.data));
      check("wr_addr",  64'(wr_addr),  64'(rec.addr));
      check("err_drop", 64'(err_drop), 64'(rec.err));
    end
    e_gnt = '0;
    found = 1'b0;
    g_idx = 0;
    if (reset === 1'b1) begin
      for (int k = 0; k < NR; k++) begin
        s_idx = (m_ptr + k) % NR;
        if (!found && req[s_idx]) begin
          found = 1'b1;
          g_idx = s_idx;
        end
      end
      if (found) e_gnt[g_idx] = 1'b1;
    end
    check("gnt", 64'(gnt), 64'(e_gnt));
    if (reset !== 1'b1) begin
      m_ptr  = 0;
      m_addr = '0;
      m_data = '0;
      sb_q.push_back('{en: '0, data: '0, addr: '0, err: 1'b0});
    end else if (found) begin
      a    = req_addr[g_idx*AW +: AW];
      d    = req_data[g_idx*DW +: DW];
      drop = (a == 4'd0) || (int'(a) >= NG);
      sb_q.push_back('{en: drop ? '0 : (NG'(1) << a), data: d, addr: a, err: drop});
      m_addr = a;
      m_data = d;
      m_ptr  = (g_idx == NR - 1) ? 0 : g_idx + 1;
    end else begin
      sb_q.push_back('{en: '0, data: m_data, addr: m_addr, err: 1'b0});
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int i, input logic [AW-1:0] ad, input logic [DW-1:0] dt);
    req_addr[i*AW +: AW] = ad;
    req_data[i*DW +: DW] = dt;
  endtask

  logic [NR-1:0] exp_seq [6];

  initial begin
    reset    = 1'b0;
    req      = 3'b111;
    req_addr = '0;
    req_data = '0;
    set_wr(0, 4'd1, 32'hA0000001);
    set_wr(1, 4'd2, 32'hA0000002);
    set_wr(2, 4'd3, 32'hA0000003);

    // Reset held two cycles with all requesting.
    next_cycle();
    next_cycle();
    check("rst_gnt",  64'(gnt),      64'(0));
    check("rst_wren", 64'(wr_en),    64'(0));
    check("rst_err",  64'(err_drop), 64'(0));

    // Round-robin with all three requesting for six cycles.
    exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100;
    exp_seq[3] = 3'b001; exp_seq[4] = 3'b010; exp_seq[5] = 3'b100;
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("rr_gnt", 64'(gnt), 64'(exp_seq[c]));
      next_cycle();
    end
    req = '0;
    next_cycle();

    // Single requester 2 writing register 5.
    set_wr(2, 4'd5, 32'hDEADBEEF);
    req = 3'b100;
    #1 check("r2_gnt", 64'(gnt), 64'(3'b100));
    next_cycle();
    req = '0;
    next_cycle();
    check("bank5", 64'(bank[5]), 64'(32'hDEADBEEF));

    // Write to read-only register 0 is dropped but still advances ptr to 2.
    set_wr(1, 4'd0, 32'h0BAD0000);
    req = 3'b010;
    #1 check("z_gnt", 64'(gnt), 64'(3'b010));
    next_cycle();
    req = '0;
    check("z_err", 64'(err_drop), 64'(1));
    check("z_wen", 64'(wr_en),    64'(0));
    set_wr(0, 4'd9, 32'h00000009);
    set_wr(1, 4'd10, 32'h0000000A);
    set_wr(2, 4'd11, 32'h0000000B);
    req = 3'b111;
    #1 check("ptr2_gnt", 64'(gnt), 64'(3'b100));
    next_cycle();
    req = '0;
    next_cycle();
    check("bank11", 64'(bank[11]), 64'(32'h0000000B));

    // Out-of-range addresses 15 and 12 (bank has 12 registers).
    set_wr(1, 4'd15, 32'h0000000F);
    req = 3'b010;
    next_cycle();
    req = '0;
    check("oor15_err", 64'(err_drop), 64'(1));
    set_wr(1, 4'd12, 32'h0000000C);
    req = 3'b010;
    next_cycle();
    req = '0;
    check("oor12_err", 64'(err_drop), 64'(1));
    next_cycle();
    check("err_pulse", 64'(err_drop), 64'(0));

    // Two consecutive writes to register 7: the later one wins.
    set_wr(0, 4'd7, 32'h11111111);
    req = 3'b001;
    next_cycle();
    set_wr(1, 4'd7, 32'h22222222);
    req = 3'b010;
    next_cycle();
    req = '0;
    check("w7_en", 64'(wr_en), 64'(12'h080));
    next_cycle();
    next_cycle();
    check("bank7", 64'(bank[7]), 64'(32'h22222222));

    // Grant to requester 0 cancelled by reset before the edge.
    set_wr(0, 4'd4, 32'hCAFE0004);
    req = 3'b001;
    #1 check("r6_gnt", 64'(gnt), 64'(3'b001));
    #1 reset = 1'b0;
    #1 check("r6_gnt_rst", 64'(gnt), 64'(0));
    next_cycle();
    req = '0;
    check("r6_wen", 64'(wr_en), 64'(0));
    next_cycle();
    check("bank4", 64'(bank[4]), 64'(0));
    reset = 1'b1;
    set_wr(0, 4'd1, 32'h00000101);
    set_wr(1, 4'd2, 32'h00000102);
    set_wr(2, 4'd3, 32'h00000103);
    req = 3'b111;
    #1 check("post_rst_gnt", 64'(gnt), 64'(3'b001));
    next_cycle();
    req = '0;
    next_cycle();
    next_cycle();

    check("sb_depth", 64'(sb_q.size() <= 1), 64'(1));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
